// File: rtl/pending_encoder_32to5_pkg.sv
// Shared constants and types for the 32-line pending encoder and its matching decoder.
package pending_encoder_32to5_pkg;

    localparam int unsigned NUM_LINES = 32;
    localparam int unsigned IDX_W     = 5;

    typedef logic [NUM_LINES-1:0] line_vec_t;
    typedef logic [IDX_W-1:0]     idx_t;

endpackage

// File: rtl/pending_encoder_32to5_if.sv
// Event/handshake bundle of the pending encoder. The master side is the
// encoder itself (it sources VALID/IDX); the slave side is the event source/consumer.
interface pending_encoder_32to5_if;
    import pending_encoder_32to5_pkg::*;

    line_vec_t SET;
    logic      CLR_ALL;
    logic      READY;
    logic      VALID;
    idx_t      IDX;
    line_vec_t PENDING;
    logic      OVERFLOW;

    modport master (
        input  SET,
        input  CLR_ALL,
        input  READY,
        output VALID,
        output IDX,
        output PENDING,
        output OVERFLOW
    );

    modport slave (
        output SET,
        output CLR_ALL,
        output READY,
        input  VALID,
        input  IDX,
        input  PENDING,
        input  OVERFLOW
    );
endinterface

// File: rtl/pending_encoder_32to5_priority_pick_32.sv
// priority_pick_32: combinational search for the first set bit at or after
// a start pointer, wrapping from line 31 back to line 0.
module priority_pick_32
    import pending_encoder_32to5_pkg::*;
(
    input  line_vec_t vec,
    input  idx_t      start,
    output logic      found_c,
    output idx_t      idx_c
);

    line_vec_t rot_c;
    idx_t      off_c;

    // Rotate so that bit 'start' lands at position 0, then take the lowest set bit.
    always_comb begin
        rot_c = (vec >> start) | (vec << (6'(NUM_LINES) - {1'b0, start}));
        off_c = '0;
        for (int i = int'(NUM_LINES) - 1; i >= 0; i--) begin
            if (rot_c[i]) begin
                off_c = idx_t'(i);
            end
        end
    end

    assign found_c = |vec;
    assign idx_c   = idx_t'(off_c + start);

endmodule

// File: rtl/pending_encoder_32to5.sv
// pending_encoder_32to5: collects one-hot event pulses into a pending register
// and issues one 5-bit index per cycle over a VALID/READY handshake.
// Optional feature: define PENDING_ENCODER_ROUND_ROBIN_EN for round-robin
// selection; otherwise the lowest pending index always wins.
module pending_encoder_32to5
    import pending_encoder_32to5_pkg::*;
(
    input logic                     CLK,
    input logic                     RESET,
    pending_encoder_32to5_if.master bus
);

    line_vec_t pend;
    logic      valid;
    idx_t      idx;
    logic      overflow;

    idx_t      start_c;
    logic      found_c;
    idx_t      pick_c;
    logic      stage_free_c;
    logic      load_c;
    line_vec_t load_mask_c;
    line_vec_t pend_next_c;
    logic      ovf_hit_c;

`ifdef PENDING_ENCODER_ROUND_ROBIN_EN
    idx_t ptr;
    assign start_c = ptr;
`else
    assign start_c = '0;
`endif

    priority_pick_32 u_pick (
        .vec     (pend),
        .start   (start_c),
        .found_c (found_c),
        .idx_c   (pick_c)
    );

    // Load decision, pending-bit update and lost-event detection.
    always_comb begin
        stage_free_c = ~valid | bus.READY;
        load_c       = stage_free_c & found_c;
        load_mask_c  = '0;
        if (load_c) begin
            load_mask_c = line_vec_t'(1) << pick_c;
        end
        pend_next_c  = (pend & ~load_mask_c) | bus.SET;
        ovf_hit_c    = |(bus.SET & pend & ~load_mask_c);
    end

    // State registers; reset and flush clear everything and drop same-cycle events.
    always_ff @(posedge CLK) begin
        if (RESET || bus.CLR_ALL) begin
            pend     <= '0;
            valid    <= 1'b0;
            idx      <= '0;
            overflow <= 1'b0;
`ifdef PENDING_ENCODER_ROUND_ROBIN_EN
            ptr      <= '0;
`endif
        end else begin
            pend     <= pend_next_c;
            overflow <= overflow | ovf_hit_c;
            if (stage_free_c) begin
                valid <= load_c;
                if (load_c) begin
                    idx <= pick_c;
                end
            end
`ifdef PENDING_ENCODER_ROUND_ROBIN_EN
            if (load_c) begin
                ptr <= idx_t'(pick_c + idx_t'(1));
            end
`endif
        end
    end

    assign bus.VALID    = valid;
    assign bus.IDX      = idx;
    assign bus.PENDING  = pend;
    assign bus.OVERFLOW = overflow;

endmodule

// File: tb/tb_pending_encoder_32to5.sv
// Testbench for pending_encoder_32to5 (fixed priority by default; define
// PENDING_ENCODER_ROUND_ROBIN_EN to exercise the round-robin build).
module tb_pending_encoder_32to5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pending_encoder_32to5_if bus ();

    pending_encoder_32to5 dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] m_pend;
    bit          m_valid;
    int          m_idx;
    bit          m_ovf;
    int          m_ptr;

    // Advance the reference model by one clock using the spec's rules.
    task automatic model_step(input logic [31:0] set, input logic clr, input logic rdy, input logic rs);
        int  k;
        bit  free;
        if (rs || clr) begin
            m_pend = 0; m_valid = 0; m_idx = 0; m_ovf = 0; m_ptr = 0;
        end else begin
            free = !m_valid || rdy;
            k = -1;
            if (free) begin
                for (int j = 0; j < 32; j++) begin
`ifdef PENDING_ENCODER_ROUND_ROBIN_EN
                    int c = (m_ptr + j) % 32;
`else
                    int c = j;
`endif
                    if (k < 0 && m_pend[c]) k = c;
                end
            end
            for (int i = 0; i < 32; i++) begin
                if (set[i] && m_pend[i] && i != k) m_ovf = 1;
            end
            if (k >= 0) begin
                m_pend[k] = 1'b0;
                m_valid   = 1;
                m_idx     = k;
                m_ptr     = (k + 1) % 32;
            end else if (free) begin
                m_valid = 0;
            end
            m_pend = m_pend | set;
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model and settle.
    task automatic step(input logic [31:0] set, input logic clr, input logic rdy, input logic rs);
        bus.SET = set; bus.CLR_ALL = clr; bus.READY = rdy; rst = rs;
        @(posedge clk);
        model_step(set, clr, rdy, rs);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            if (c < 2) step(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
            else       step(32'h0, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (bus.VALID !== 1'b0 || bus.IDX !== 5'd0 || bus.PENDING !== 32'h0 || bus.OVERFLOW !== 1'b0)
                $display("FAIL reset_state cyc=%0d got v=%b i=%0d p=%h o=%b exp all zero",
                         c, bus.VALID, bus.IDX, bus.PENDING, bus.OVERFLOW);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        step(32'h0, 1'b0, 1'b1, 1'b1);
        step(32'h0000_0010, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (bus.PENDING !== 32'h10 || bus.VALID !== 1'b0)
            $display("FAIL single_pend got p=%h v=%b exp p=00000010 v=0", bus.PENDING, bus.VALID);
        else n_pass++;
        step(32'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (bus.VALID !== 1'b1 || bus.IDX !== 5'd4 || bus.PENDING !== 32'h0)
            $display("FAIL single_issue got v=%b i=%0d p=%h exp v=1 i=4 p=0", bus.VALID, bus.IDX, bus.PENDING);
        else n_pass++;
        step(32'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (bus.VALID !== 1'b0 || bus.PENDING !== 32'h0)
            $display("FAIL single_drain got v=%b p=%h exp v=0 p=0", bus.VALID, bus.PENDING);
        else n_pass++;
    endtask

    task automatic test_multi();
        int exp_seq[3] = '{0, 1, 31};
        step(32'h0, 1'b0, 1'b1, 1'b1);
        step(32'h8000_0003, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (bus.PENDING !== 32'h8000_0003)
            $display("FAIL multi_pend got %h exp 80000003", bus.PENDING);
        else n_pass++;
        for (int n = 0; n < 3; n++) begin
            step(32'h0, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (bus.VALID !== 1'b1 || int'(bus.IDX) != exp_seq[n])
                $display("FAIL multi_order n=%0d got v=%b i=%0d exp v=1 i=%0d", n, bus.VALID, bus.IDX, exp_seq[n]);
            else n_pass++;
        end
        step(32'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (bus.VALID !== 1'b0 || bus.PENDING !== 32'h0)
            $display("FAIL multi_drain got v=%b p=%h exp v=0 p=0", bus.VALID, bus.PENDING);
        else n_pass++;
        // Round-robin pointer is now back at 0: a lone line 1 then line 0 must come out 1 first only if pending alone.
        step(32'h0000_0003, 1'b0, 1'b1, 1'b0);
        step(32'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (bus.VALID !== 1'b1 || bus.IDX !== 5'd0)
            $display("FAIL multi_wrap got v=%b i=%0d exp v=1 i=0", bus.VALID, bus.IDX);
        else n_pass++;
    endtask

    task automatic test_hold_two();
        int prev = -1;
        step(32'h0, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 12; c++) begin
            step(32'h0000_0024, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (bus.VALID !== m_valid || bus.PENDING !== m_pend || bus.OVERFLOW !== m_ovf ||
                (m_valid && int'(bus.IDX) != m_idx))
                $display("FAIL hold_two_model cyc=%0d got v=%b i=%0d p=%h o=%b exp v=%b i=%0d p=%h o=%b",
                         c, bus.VALID, bus.IDX, bus.PENDING, bus.OVERFLOW, m_valid, m_idx, m_pend, m_ovf);
            else n_pass++;
            if (bus.VALID === 1'b1) begin
                n_checks++;
`ifdef PENDING_ENCODER_ROUND_ROBIN_EN
                if ((bus.IDX != 5'd2 && bus.IDX != 5'd5) || int'(bus.IDX) == prev)
                    $display("FAIL hold_two_alternate cyc=%0d got i=%0d prev=%0d exp other of 2/5", c, bus.IDX, prev);
                else n_pass++;
`else
                if (bus.IDX !== 5'd2)
                    $display("FAIL hold_two_fixed cyc=%0d got i=%0d exp i=2", c, bus.IDX);
                else n_pass++;
`endif
                prev = int'(bus.IDX);
            end
        end
        n_checks++;
        if (bus.OVERFLOW !== 1'b1)
            $display("FAIL hold_two_overflow got %b exp 1", bus.OVERFLOW);
        else n_pass++;
    endtask

    task automatic test_stall();
        step(32'h0, 1'b0, 1'b1, 1'b1);
        step(32'h1, 1'b0, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.VALID !== 1'b1 || bus.IDX !== 5'd0 || bus.PENDING !== 32'h0)
            $display("FAIL stall_load got v=%b i=%0d p=%h exp v=1 i=0 p=0", bus.VALID, bus.IDX, bus.PENDING);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            step(32'h0, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (bus.VALID !== 1'b1 || bus.IDX !== 5'd0)
                $display("FAIL stall_hold cyc=%0d got v=%b i=%0d exp v=1 i=0", c, bus.VALID, bus.IDX);
            else n_pass++;
        end
        step(32'h1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.PENDING !== 32'h1 || bus.OVERFLOW !== 1'b0 || bus.VALID !== 1'b1 || bus.IDX !== 5'd0)
            $display("FAIL stall_repend got p=%h o=%b v=%b i=%0d exp p=1 o=0 v=1 i=0",
                     bus.PENDING, bus.OVERFLOW, bus.VALID, bus.IDX);
        else n_pass++;
        step(32'h1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.OVERFLOW !== 1'b1)
            $display("FAIL stall_overflow got %b exp 1", bus.OVERFLOW);
        else n_pass++;
    endtask

    task automatic test_clear();
        step(32'h0, 1'b0, 1'b1, 1'b1);
        step(32'h0000_00F1, 1'b0, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.VALID !== 1'b1 || bus.IDX !== 5'd0 || bus.PENDING !== 32'hF0)
            $display("FAIL clear_setup got v=%b i=%0d p=%h exp v=1 i=0 p=f0", bus.VALID, bus.IDX, bus.PENDING);
        else n_pass++;
        step(32'h0000_0010, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.OVERFLOW !== 1'b1)
            $display("FAIL clear_ovf_setup got %b exp 1", bus.OVERFLOW);
        else n_pass++;
        step(32'h0000_0003, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (bus.VALID !== 1'b0 || bus.PENDING !== 32'h0 || bus.OVERFLOW !== 1'b0)
            $display("FAIL clear_flush got v=%b p=%h o=%b exp v=0 p=0 o=0", bus.VALID, bus.PENDING, bus.OVERFLOW);
        else n_pass++;
        step(32'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (bus.VALID !== 1'b0 || bus.PENDING !== 32'h0)
            $display("FAIL clear_set_dropped got v=%b p=%h exp v=0 p=0", bus.VALID, bus.PENDING);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] set;
        logic        clr, rdy, rs;
        int          r;
        step(32'h0, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 600; c++) begin
            r = int'($urandom_range(0, 3));
            if (r == 0)      set = $urandom;
            else if (r == 1) set = 32'h1 << $urandom_range(0, 31);
            else             set = 32'h0;
            clr = ($urandom_range(0, 49) == 0);
            rs  = ($urandom_range(0, 99) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            step(set, clr, rdy, rs);
            n_checks++;
            if (bus.VALID !== m_valid || bus.PENDING !== m_pend || bus.OVERFLOW !== m_ovf ||
                (m_valid && int'(bus.IDX) != m_idx))
                $display("FAIL random_model cyc=%0d got v=%b i=%0d p=%h o=%b exp v=%b i=%0d p=%h o=%b",
                         c, bus.VALID, bus.IDX, bus.PENDING, bus.OVERFLOW, m_valid, m_idx, m_pend, m_ovf);
            else n_pass++;
        end
    endtask

    initial begin
        bus.SET = '0; bus.CLR_ALL = 1'b0; bus.READY = 1'b0;
        m_pend = 0; m_valid = 0; m_idx = 0; m_ovf = 0; m_ptr = 0;
        test_reset();
        test_single();
        test_multi();
        test_hold_two();
        test_stall();
        test_clear();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pending_encoder_32to5.md
# pending_encoder_32to5

Registered 32-to-5 encoder: collects single-cycle event pulses on 32 one-hot lines into a pending register, then emits one 5-bit index at a time over a VALID/READY handshake, clearing each bit as it is issued. It is the encode side of the 5-to-32 one-hot decoding used for register-index selection. It serialises per-register events (write-back completions, scoreboard releases) into index form for a single consumer.

## Interface
- Parameters: none. Widths are fixed at 32 lines and a 5-bit index.
- CLK      in   1   rising-edge clock
- RESET    in   1   synchronous, active-high reset
- SET      in   32  event pulses; bit i high for one cycle marks line i pending
- CLR_ALL  in   1   synchronous flush of all pending state and the output stage
- READY    in   1   consumer accepts IDX when VALID & READY
- VALID    out  1   IDX holds an issued index
- IDX      out  5   issued line index, binary
- PENDING  out  32  current pending register, excluding the line held in the output stage
- OVERFLOW out  1   sticky flag: an event was lost by merging into an already-pending bit

## Operation
- State:
  - PEND[31:0]
  - output stage (VALID, IDX)
  - OVERFLOW
  - round-robin pointer PTR[4:0] (only when the macro is defined)
- Reset/flush (RESET or CLR_ALL): PEND=0, VALID=0, IDX=0, OVERFLOW=0, PTR=0. RESET takes priority over CLR_ALL. SET and READY are ignored in that cycle.
- Output stage is free when VALID=0, or when VALID & READY (the handshake fires this cycle).
- Load rule: if the stage is free and PEND≠0, select index k from PEND. Next cycle: VALID=1, IDX=k, and PEND[k] is cleared.
  - If the stage is free and PEND=0, then VALID=0 next cycle.
- Selection uses the registered PEND only. Same-cycle SET bits are never selected in the cycle they arrive.
- Next PEND = (PEND & ~load_mask) | SET, where load_mask is the one-hot of k when a load occurs and 0 otherwise.
- Overflow: OVERFLOW is set when any bit satisfies SET[i] & PEND[i] & ~load_mask[i]. It stays set until RESET or CLR_ALL.
  - A SET on the line currently held in the output stage is not an overflow; it re-pends normally.
- While VALID=1 and READY=0, IDX and VALID are held stable.

## Timing
- Latency: a SET pulse in cycle n appears in PENDING at n+1 and earliest on VALID/IDX at n+2.
- Throughput: one index per cycle while READY=1 and PEND≠0.
- All outputs are registered, with no combinational path from inputs to outputs.
- Reset values: VALID=0, IDX=0, PENDING=0, OVERFLOW=0.
- Reset mid-transfer: an issued but unaccepted index is discarded and not replayed.

## Configuration
- `PENDING_ENCODER_ROUND_ROBIN_EN` defined:
  - Search starts at PTR and wraps 31→0.
  - On each load, PTR = k+1 mod 32.
  - No line waits more than 31 issues once pending.
- Macro undefined: fixed priority, lowest set index wins. The PTR register and wrap logic are not built.

## Structure
- Shared package holds:
  - NUM_LINES = 32
  - IDX_W = 5
  - typedefs for the line vector and the index
- The decoder side uses the same constants.
- One combinational sub-module, `priority_pick_32`:
  - Inputs: 32-bit vector and 5-bit start pointer (tied to 0 in fixed mode).
  - Outputs: found flag and 5-bit index.
- The top level holds all registers, the load/clear logic and the overflow logic.

## Test plan
- RESET high 2 cycles with SET=32'hFFFF_FFFF → VALID=0, IDX=0, PENDING=0, OVERFLOW=0 throughout and after.
- SET=32'h0000_0010 for one cycle, READY=1 → PENDING=32'h10 next cycle; VALID=1, IDX=4 one cycle later; then VALID=0, PENDING=0.
- SET=32'h8000_0003 at once, READY=1 → fixed mode issues IDX 0,1,31 on consecutive cycles. Round-robin mode from PTR=0 gives the same order, and PTR ends at 0 (wrap).
- Round-robin: hold SET[2] and SET[5] high every cycle, READY=1 → IDX alternates 2,5,2,5 with no starvation. In fixed mode IDX=2 repeats while bit 5 stays pending and OVERFLOW asserts.
- SET=32'h1, READY=0 for 4 cycles → VALID=1, IDX=0 held stable. A second SET=32'h1 re-pends bit 0 (PENDING=1), OVERFLOW=0; a third SET=32'h1 → OVERFLOW=1.
- CLR_ALL pulsed while VALID=1 and PENDING=32'hF0 → next cycle VALID=0, PENDING=0, OVERFLOW=0. A SET in the same cycle is dropped.
